// File: rtl/pm_loader.sv
// pm_loader: framed byte-stream loader for program memory; holds the core until a good checksum arrives
module pm_loader #(
    parameter int ADDR_W = 5,
    parameter int INS_W  = 13,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic              PM_WE,
    output logic [ADDR_W-1:0] PM_WAddr,
    output logic [INS_W-1:0]  PM_WData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W:0]   WordCount
);
    localparam logic [2:0] S_IDLE = 3'd0, S_LEN = 3'd1, S_HI = 3'd2, S_LO = 3'd3,
                           S_WR = 3'd4, S_CSUM = 3'd5, S_DONE = 3'd6, S_ERR = 3'd7;
    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, wcnt_q, wcnt_d, idx_n;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        sum_q, sum_d, sum_n, lo_q, lo_d;
    logic [INS_W-9:0]  hi_q, hi_d;
    logic              acc;

    assign RxReady   = state_q inside {S_LEN, S_HI, S_LO, S_CSUM};
    assign acc       = RxValid & RxReady;
    assign sum_n     = sum_q + RxData;
    assign idx_n     = {1'b0, idx_q} + (ADDR_W+1)'(1);
    assign PM_WE     = state_q == S_WR;
    assign PM_WAddr  = idx_q;
    assign PM_WData  = {hi_q, lo_q};
    assign CpuHold   = state_q != S_IDLE && state_q != S_DONE;
    assign Done      = state_q == S_DONE;
    assign Error     = state_q == S_ERR;
    assign WordCount = wcnt_q;

    // frame parser: validate LEN/HI, accumulate checksum, write one word per pair
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (Start) begin
                state_d = S_LEN;
                len_d   = '0;
                wcnt_d  = '0;
                idx_d   = '0;
                sum_d   = '0;
            end
            S_LEN: if (acc) begin
                if (RxData == 8'd0 || {1'b0, RxData} > DEPTH_B) state_d = S_ERR;
                else begin
                    len_d   = RxData[ADDR_W:0];
                    sum_d   = sum_n;
                    state_d = S_HI;
                end
            end
            S_HI: if (acc) begin
                if (RxData[7:5] != 3'd0) state_d = S_ERR;
                else begin
                    hi_d    = RxData[INS_W-9:0];
                    sum_d   = sum_n;
                    state_d = S_LO;
                end
            end
            S_LO: if (acc) begin
                lo_d    = RxData;
                sum_d   = sum_n;
                state_d = S_WR;
            end
            S_WR: begin
                wcnt_d = wcnt_q + (ADDR_W+1)'(1);
                if (idx_n == len_q) state_d = S_CSUM;
                else begin
                    idx_d   = idx_n[ADDR_W-1:0];
                    state_d = S_HI;
                end
            end
            S_CSUM: if (acc) state_d = sum_n == 8'd0 ? S_DONE : S_ERR;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_pm_loader.sv
// tb_pm_loader: directed frame vectors and corner sequences for pm_loader
module tb_pm_loader;
    logic        clk = 1'b0;
    logic        Reset, Start, RxValid;
    logic [7:0]  RxData;
    logic        RxReady, PM_WE, CpuHold, Done, Error;
    logic [4:0]  PM_WAddr;
    logic [12:0] PM_WData;
    logic [5:0]  WordCount;

    int checks = 0;
    int errors = 0;
    int wr_n = 0;
    logic [4:0]  wa [256];
    logic [12:0] wd [256];

    pm_loader dut (
        .clk(clk), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .PM_WE(PM_WE), .PM_WAddr(PM_WAddr), .PM_WData(PM_WData),
        .CpuHold(CpuHold), .Done(Done), .Error(Error), .WordCount(WordCount)
    );

    always #5 clk = ~clk;

    // capture every write strobe away from the active edge
    always @(negedge clk) begin
        if (PM_WE && wr_n < 256) begin
            wa[wr_n] = PM_WAddr;
            wd[wr_n] = PM_WData;
            wr_n = wr_n + 1;
        end
    end

    typedef struct {
        int          nb;
        logic [7:0]  b [6];
        bit          exp_done;
        bit          exp_err;
        int          exp_wc;
        int          exp_wr;
        logic [12:0] exp_wd [2];
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_session();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("start_hold", CpuHold, 1);
        chk("start_ready", RxReady, 1);
        chk("start_clear", {Done, Error}, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int t = 0;
        RxValid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        RxData  = b;
        RxValid = 1'b1;
        while (!RxReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 1);
        @(negedge clk);
        RxValid = 1'b0;
    endtask

    vec_t vecs [5];
    logic [7:0]  big [66];
    logic [12:0] big_wd [32];

    task automatic build_big();
        logic [7:0] s = 8'h20;
        big[0] = 8'h20;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] hi = {3'b000, 5'(i)};
            logic [7:0] lo = 8'(i * 37 + 5);
            big[1 + 2*i] = hi;
            big[2 + 2*i] = lo;
            big_wd[i] = {hi[4:0], lo};
            s = s + hi + lo;
        end
        big[65] = 8'd0 - s;
    endtask

    task automatic run_big(input string tag);
        int base;
        base = wr_n;
        start_session();
        for (int i = 0; i < 66; i++) send_byte(big[i], 2);
        chk({tag, "_done"}, Done, 1);
        chk({tag, "_err"}, Error, 0);
        chk({tag, "_hold"}, CpuHold, 0);
        chk({tag, "_wc"}, WordCount, 32);
        chk({tag, "_nwr"}, wr_n - base, 32);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_addr"}, wa[base + i], i);
            chk({tag, "_data"}, wd[base + i], big_wd[i]);
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{6, '{8'h02, 8'h1A, 8'hBC, 8'h00, 8'h01, 8'h27}, 1, 0, 2, 2, '{13'h1ABC, 13'h0001}};
        vecs[1] = '{6, '{8'h02, 8'h1A, 8'hBC, 8'h00, 8'h01, 8'h28}, 0, 1, 2, 2, '{13'h1ABC, 13'h0001}};
        vecs[2] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, '{13'h0, 13'h0}};
        vecs[3] = '{1, '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, '{13'h0, 13'h0}};
        vecs[4] = '{2, '{8'h01, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, '{13'h0, 13'h0}};
        build_big();

        Reset = 1'b1; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        RxValid = 1'b1; RxData = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", RxReady, 0);
            chk("idle_we", PM_WE, 0);
            chk("idle_outs", {CpuHold, Done, Error}, 0);
            chk("idle_wc", WordCount, 0);
            chk("idle_addr_data", {PM_WAddr, PM_WData}, 0);
        end
        RxValid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            base = wr_n;
            start_session();
            for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i], 0);
            chk("vec_done", Done, vecs[v].exp_done);
            chk("vec_err", Error, vecs[v].exp_err);
            chk("vec_hold", CpuHold, !vecs[v].exp_done);
            chk("vec_ready", RxReady, 0);
            chk("vec_wc", WordCount, vecs[v].exp_wc);
            chk("vec_nwr", wr_n - base, vecs[v].exp_wr);
            for (int i = 0; i < vecs[v].exp_wr; i++) begin
                chk("vec_addr", wa[base + i], i);
                chk("vec_data", wd[base + i], vecs[v].exp_wd[i]);
            end
        end

        start_session();
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        send_byte(8'hAA, 0);
        chk("lo_we", PM_WE, 1);
        chk("lo_ready", RxReady, 0);
        chk("lo_addr", PM_WAddr, 0);
        chk("lo_data", PM_WData, 13'h05AA);
        chk("lo_wc_before", WordCount, 0);
        @(negedge clk);
        chk("wr_wc_after", WordCount, 1);
        chk("wr_we_off", PM_WE, 0);
        chk("csum_ready", RxReady, 1);
        send_byte(8'h50, 0);
        chk("single_done", Done, 1);
        chk("single_hold", CpuHold, 0);

        run_big("big");

        start_session();
        for (int i = 0; i < 21; i++) send_byte(big[i], 2);
        @(negedge clk);
        chk("mid_wc", WordCount, 10);
        chk("mid_hold", CpuHold, 1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("rst_ready", RxReady, 0);
        chk("rst_outs", {CpuHold, Done, Error, PM_WE}, 0);
        chk("rst_wc", WordCount, 0);
        run_big("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
